// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch control core.
package stopwatch_pkg;

   localparam int unsigned FIELD_W = 8;

   localparam logic [FIELD_W-1:0] CS_MAX  = 8'd99;
   localparam logic [FIELD_W-1:0] SEC_MAX = 8'd59;
   localparam logic [FIELD_W-1:0] MIN_MAX = 8'd59;
   localparam logic [FIELD_W-1:0] HR_MAX  = 8'd99;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_CLR   = 2'd3
   } sw_state_e;

   typedef enum logic [1:0] {
      OP_START = 2'd0,
      OP_STOP  = 2'd1,
      OP_CLEAR = 2'd2,
      OP_LAP   = 2'd3
   } sw_op_e;

   typedef struct packed {
      logic [FIELD_W-1:0] hr;
      logic [FIELD_W-1:0] min;
      logic [FIELD_W-1:0] sec;
      logic [FIELD_W-1:0] cs;
   } sw_time_t;

endpackage

// File: rtl/stopwatch_time_counter.sv
// hh:mm:ss.cs carry cascade; advances one hundredth per tick, wrap strobes
// on the 99:59:59.99 -> 00:00:00.00 transition.
module stopwatch_time_counter
   import stopwatch_pkg::*;
(
   input  logic     ACLK,
   input  logic     ARESETN,
   input  logic     clr,
   input  logic     tick,
   output sw_time_t value,
   output logic     wrap
);

   sw_time_t count;
   sw_time_t next;

   // Next time value: ripple carries from cs up through hours
   always_comb begin
      next = count;
      wrap = 1'b0;
      if (tick) begin
         if (count.cs != CS_MAX) begin
            next.cs = count.cs + FIELD_W'(1);
         end else begin
            next.cs = '0;
            if (count.sec != SEC_MAX) begin
               next.sec = count.sec + FIELD_W'(1);
            end else begin
               next.sec = '0;
               if (count.min != MIN_MAX) begin
                  next.min = count.min + FIELD_W'(1);
               end else begin
                  next.min = '0;
                  if (count.hr != HR_MAX) begin
                     next.hr = count.hr + FIELD_W'(1);
                  end else begin
                     next.hr = '0;
                     wrap    = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Time register; clear wins over a coincident tick
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else begin
         count <= next;
      end
   end

   assign value = count;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: command/button arbitration, run/pause/clear FSM,
// tick prescaler and lap capture. Define STOPWATCH_LAP_EN to build the lap
// register; otherwise LAP is accepted and ignored and lap outputs are 0.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100000000,
   parameter int unsigned TICK_HZ     = 100
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic        btn_start_stop,
   input  logic        btn_clear,
   output logic [31:0] time_o,
   output logic [1:0]  state_o,
   output logic        overflow_o,
   output logic [31:0] lap_time_o,
   output logic        lap_valid_o
);

   localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int unsigned PW  = $clog2(DIV);

   sw_state_e      state;
   sw_state_e      state_next;
   logic [PW-1:0]  presc;
   logic           tick;
   logic           ev_valid;
   sw_op_e         ev_op;
   logic           clear_ev;
   logic           wrap;
   sw_time_t       cur;
`ifdef STOPWATCH_LAP_EN
   logic           lap_ev;
`endif

   assign tick = (state == ST_RUN) && (presc == PW'(DIV - 1));

   // Event arbitration: accepted software command first, then clear button,
   // then start/stop button (interpreted by state); buttons dead in CLR
   always_comb begin
      ev_valid = 1'b0;
      ev_op    = OP_START;
      if (cmd_valid && cmd_ready) begin
         ev_valid = 1'b1;
         ev_op    = sw_op_e'(cmd_op);
      end else if (state != ST_CLR) begin
         if (btn_clear) begin
            ev_valid = 1'b1;
            ev_op    = OP_CLEAR;
         end else if (btn_start_stop) begin
            ev_valid = 1'b1;
            ev_op    = (state == ST_RUN) ? OP_STOP : OP_START;
         end
      end
   end

   // Next-state and side-effect decode for the winning event
   always_comb begin
      state_next = state;
      clear_ev   = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_ev     = 1'b0;
`endif
      if (state == ST_CLR) begin
         state_next = ST_IDLE;
      end else if (ev_valid) begin
         case (ev_op)
            OP_START: if (state != ST_RUN) state_next = ST_RUN;
            OP_STOP:  if (state == ST_RUN) state_next = ST_PAUSE;
            OP_CLEAR: begin
               state_next = ST_CLR;
               clear_ev   = 1'b1;
            end
            OP_LAP: begin
`ifdef STOPWATCH_LAP_EN
               lap_ev = (state == ST_RUN) || (state == ST_PAUSE);
`endif
            end
            default: ;
         endcase
      end
   end

   // FSM state and registered ready (low only while in CLR)
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b0;
      end else begin
         state     <= state_next;
         cmd_ready <= (state_next != ST_CLR);
      end
   end

   // Prescaler: advances only in RUN and keeps its phase across PAUSE
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         presc <= '0;
      end else if (clear_ev) begin
         presc <= '0;
      end else if (state == ST_RUN) begin
         presc <= tick ? '0 : presc + PW'(1);
      end
   end

   // Sticky overflow, set by the hours wrap and cleared on CLR entry
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         overflow_o <= 1'b0;
      end else if (clear_ev) begin
         overflow_o <= 1'b0;
      end else if (wrap) begin
         overflow_o <= 1'b1;
      end
   end

   stopwatch_time_counter u_count (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .clr     (clear_ev),
      .tick    (tick),
      .value   (cur),
      .wrap    (wrap)
   );

   assign state_o = state;
   assign time_o  = cur;

`ifdef STOPWATCH_LAP_EN
   // Lap capture takes the pre-increment time when a tick coincides
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         lap_time_o  <= '0;
         lap_valid_o <= 1'b0;
      end else begin
         lap_valid_o <= lap_ev;
         if (clear_ev) begin
            lap_time_o <= '0;
         end else if (lap_ev) begin
            lap_time_o <= time_o;
         end
      end
   end
`else
   assign lap_time_o  = '0;
   assign lap_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl at DIV = 10.
module tb_stopwatch_ctrl;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic        btn_start_stop = 1'b0;
   logic        btn_clear = 1'b0;
   logic [31:0] time_o;
   logic [1:0]  state_o;
   logic        overflow_o;
   logic [31:0] lap_time_o;
   logic        lap_valid_o;

   int checks = 0;
   int errors = 0;

   stopwatch_ctrl #(
      .CLK_FREQ_HZ (1000),
      .TICK_HZ     (100)
   ) dut (
      .ACLK           (ACLK),
      .ARESETN        (ARESETN),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .btn_start_stop (btn_start_stop),
      .btn_clear      (btn_clear),
      .time_o         (time_o),
      .state_o        (state_o),
      .overflow_o     (overflow_o),
      .lap_time_o     (lap_time_o),
      .lap_valid_o    (lap_valid_o)
   );

   always #5 ACLK = ~ACLK;

   // Drive one command for one edge; returns at the negedge after acceptance
   task automatic send(input logic [1:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(negedge ACLK);
      cmd_valid = 1'b0;
   endtask

   task automatic go_idle();
      send(2'd2);
      @(negedge ACLK);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge ACLK);
      checks++;
      if ({time_o, state_o, overflow_o, cmd_ready, lap_time_o, lap_valid_o} !== 69'd0) begin
         errors++;
         $display("FAIL reset_outputs: time=%h state=%0d ovf=%b rdy=%b lap=%h lv=%b required all 0",
                  time_o, state_o, overflow_o, cmd_ready, lap_time_o, lap_valid_o);
      end
      ARESETN = 1'b1;
      @(negedge ACLK);
      checks++;
      if (cmd_ready !== 1'b1 || state_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b state=%0d required rdy=1 state=0", cmd_ready, state_o);
      end
   endtask

   task automatic test_start();
      send(2'd0);
      checks++;
      if (state_o !== 2'd1) begin
         errors++;
         $display("FAIL start_state: state=%0d required 1", state_o);
      end
      repeat (9) @(negedge ACLK);
      checks++;
      if (time_o !== 32'h0) begin
         errors++;
         $display("FAIL start_before_tick: time=%h required 00000000", time_o);
      end
      @(negedge ACLK);
      checks++;
      if (time_o !== 32'h1) begin
         errors++;
         $display("FAIL start_first_tick: time=%h required 00000001", time_o);
      end
      repeat (989) @(negedge ACLK);
      checks++;
      if (time_o !== 32'h63) begin
         errors++;
         $display("FAIL start_cs99: time=%h required 00000063", time_o);
      end
      @(negedge ACLK);
      checks++;
      if (time_o !== 32'h100) begin
         errors++;
         $display("FAIL start_sec_carry: time=%h required 00000100", time_o);
      end
   endtask

   task automatic test_pause_resume();
      go_idle();
      send(2'd0);
      repeat (36) @(negedge ACLK);
      send(2'd1);
      checks++;
      if (state_o !== 2'd2 || time_o !== 32'h3) begin
         errors++;
         $display("FAIL pause_stop: state=%0d time=%h required 2 00000003", state_o, time_o);
      end
      repeat (50) @(negedge ACLK);
      checks++;
      if (time_o !== 32'h3) begin
         errors++;
         $display("FAIL pause_hold: time=%h required 00000003", time_o);
      end
      send(2'd0);
      repeat (2) @(negedge ACLK);
      checks++;
      if (time_o !== 32'h3) begin
         errors++;
         $display("FAIL resume_early: time=%h required 00000003", time_o);
      end
      @(negedge ACLK);
      checks++;
      if (time_o !== 32'h4) begin
         errors++;
         $display("FAIL resume_retained: time=%h required 00000004", time_o);
      end
   endtask

   task automatic test_overflow();
      go_idle();
      send(2'd0);
      send(2'd1);
      force dut.u_count.count = 32'h633B3B63;
      repeat (2) @(negedge ACLK);
      release dut.u_count.count;
      @(negedge ACLK);
      checks++;
      if (time_o !== 32'h633B3B63) begin
         errors++;
         $display("FAIL preload: time=%h required 633b3b63", time_o);
      end
      send(2'd0);
      repeat (8) @(negedge ACLK);
      checks++;
      if (time_o !== 32'h633B3B63 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL pre_wrap: time=%h ovf=%b required 633b3b63 0", time_o, overflow_o);
      end
      @(negedge ACLK);
      checks++;
      if (time_o !== 32'h0 || overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL wrap: time=%h ovf=%b required 00000000 1", time_o, overflow_o);
      end
      repeat (15) @(negedge ACLK);
      checks++;
      if (overflow_o !== 1'b1 || time_o !== 32'h1) begin
         errors++;
         $display("FAIL ovf_sticky: ovf=%b time=%h required 1 00000001", overflow_o, time_o);
      end
      send(2'd2);
      checks++;
      if (state_o !== 2'd3 || cmd_ready !== 1'b0 || overflow_o !== 1'b0 || time_o !== 32'h0) begin
         errors++;
         $display("FAIL clear_entry: state=%0d rdy=%b ovf=%b time=%h required 3 0 0 00000000",
                  state_o, cmd_ready, overflow_o, time_o);
      end
      @(negedge ACLK);
      checks++;
      if (state_o !== 2'd0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_exit: state=%0d rdy=%b required 0 1", state_o, cmd_ready);
      end
   endtask

   task automatic test_arbitration();
      go_idle();
      send(2'd0);
      btn_start_stop = 1'b1;
      send(2'd1);
      btn_start_stop = 1'b0;
      checks++;
      if (state_o !== 2'd2) begin
         errors++;
         $display("FAIL arb_run_stop: state=%0d required 2", state_o);
      end
      // In PAUSE the button would mean START; the STOP command must win
      btn_start_stop = 1'b1;
      send(2'd1);
      btn_start_stop = 1'b0;
      checks++;
      if (state_o !== 2'd2) begin
         errors++;
         $display("FAIL arb_pause_drop: state=%0d required 2", state_o);
      end
      btn_start_stop = 1'b1;
      @(negedge ACLK);
      btn_start_stop = 1'b0;
      checks++;
      if (state_o !== 2'd1) begin
         errors++;
         $display("FAIL btn_start: state=%0d required 1", state_o);
      end
      btn_clear = 1'b1;
      @(negedge ACLK);
      btn_clear = 1'b0;
      btn_start_stop = 1'b1;
      @(negedge ACLK);
      btn_start_stop = 1'b0;
      checks++;
      if (state_o !== 2'd0) begin
         errors++;
         $display("FAIL btn_in_clr: state=%0d required 0", state_o);
      end
   endtask

   task automatic test_lap();
      go_idle();
      send(2'd0);
      repeat (99) @(negedge ACLK);
      send(2'd3);
`ifdef STOPWATCH_LAP_EN
      checks++;
      if (time_o !== 32'hA || lap_time_o !== 32'h9 || lap_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL lap_capture: time=%h lap=%h lv=%b required 0000000a 00000009 1",
                  time_o, lap_time_o, lap_valid_o);
      end
      @(negedge ACLK);
      checks++;
      if (lap_valid_o !== 1'b0 || lap_time_o !== 32'h9) begin
         errors++;
         $display("FAIL lap_pulse: lv=%b lap=%h required 0 00000009", lap_valid_o, lap_time_o);
      end
      send(2'd2);
      checks++;
      if (lap_time_o !== 32'h0) begin
         errors++;
         $display("FAIL lap_clear: lap=%h required 00000000", lap_time_o);
      end
`else
      checks++;
      if (time_o !== 32'hA || lap_time_o !== 32'h0 || lap_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL lap_disabled: time=%h lap=%h lv=%b required 0000000a 00000000 0",
                  time_o, lap_time_o, lap_valid_o);
      end
      @(negedge ACLK);
      checks++;
      if (lap_valid_o !== 1'b0 || lap_time_o !== 32'h0) begin
         errors++;
         $display("FAIL lap_disabled_after: lv=%b lap=%h required 0 00000000", lap_valid_o, lap_time_o);
      end
`endif
   endtask

   task automatic test_reset_mid();
      go_idle();
      send(2'd0);
      send(2'd1);
      force dut.u_count.count = 32'h00010203;
      repeat (2) @(negedge ACLK);
      release dut.u_count.count;
      send(2'd0);
      repeat (2) @(negedge ACLK);
      checks++;
      if (time_o !== 32'h00010203 || state_o !== 2'd1) begin
         errors++;
         $display("FAIL midrun_setup: time=%h state=%0d required 00010203 1", time_o, state_o);
      end
      #2 ARESETN = 1'b0;
      #1;
      checks++;
      if ({time_o, state_o, overflow_o, cmd_ready, lap_time_o, lap_valid_o} !== 69'd0) begin
         errors++;
         $display("FAIL async_reset: time=%h state=%0d ovf=%b rdy=%b lap=%h lv=%b required all 0",
                  time_o, state_o, overflow_o, cmd_ready, lap_time_o, lap_valid_o);
      end
      repeat (3) @(negedge ACLK);
      checks++;
      if (time_o !== 32'h0 || cmd_ready !== 1'b0 || state_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_hold: time=%h rdy=%b state=%0d required 00000000 0 0",
                  time_o, cmd_ready, state_o);
      end
      ARESETN = 1'b1;
      @(negedge ACLK);
      checks++;
      if (state_o !== 2'd0 || cmd_ready !== 1'b1 || time_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_after: state=%0d rdy=%b time=%h required 0 1 00000000",
                  state_o, cmd_ready, time_o);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_pause_resume();
      test_overflow();
      test_arbitration();
      test_lap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control core behind the AXI4-Lite stopwatch register slave.
- Sequences a run/pause/clear state machine and a prescaled hundredths-of-second time counter.
- Arbitrates commands from the software register interface and from front-panel button pulses.
- Exposes the packed current time and a captured lap time for read-back through the slave registers.

Parameters:
- CLK_FREQ_HZ, 100000000, ACLK frequency.
- TICK_HZ, 100, count rate in hundredths of a second. DIV = CLK_FREQ_HZ/TICK_HZ, which must be an integer >= 2.

Ports:
- ACLK  input  1  clock.
- ARESETN  input  1  asynchronous active-low reset.
- cmd_valid  input  1  software command valid.
- cmd_ready  output  1  command accepted on the edge where cmd_valid && cmd_ready.
- cmd_op  input  2  0=START, 1=STOP, 2=CLEAR, 3=LAP.
- btn_start_stop  input  1  single-cycle pulse, already synchronized and debounced.
- btn_clear  input  1  single-cycle pulse, already synchronized and debounced.
- time_o  output  32  [31:24] hours 0-99, [23:16] min 0-59, [15:8] sec 0-59, [7:0] cs 0-99, binary.
- state_o  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=CLR.
- overflow_o  output  1  sticky flag: hours wrapped.
- lap_time_o  output  32  captured time, same packing as time_o.
- lap_valid_o  output  1  one-cycle pulse when lap_time_o updates.

Behaviour:
- Reset: all outputs and internal counters are 0, state IDLE, cmd_ready=0 while ARESETN is low. Assertion mid-count clears everything immediately. cmd_ready goes to 1 on the first edge after release.
- cmd_ready is 1 in IDLE, RUN and PAUSE, and 0 in CLR.
- Event arbitration: a software command has priority. A button pulse in the same cycle as an accepted command is discarded. Buttons are ignored in CLR.
- btn_start_stop behaves as START in IDLE or PAUSE, and as STOP in RUN.
- btn_clear behaves as CLEAR.
- State transitions, registered so state_o changes on the edge after acceptance:
  - IDLE: START -> RUN.
  - RUN: STOP -> PAUSE.
  - PAUSE: START -> RUN; the prescaler keeps its value, so there is no partial-tick loss.
  - Any state except CLR: CLEAR -> CLR.
  - CLR -> IDLE unconditionally after 1 cycle. On entry to CLR, the time counters, prescaler and overflow_o are zeroed.
  - START in RUN, STOP in IDLE/PAUSE, and LAP in IDLE/CLR are accepted and have no effect.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - The wrap cycle generates tick; cs increments on that same edge, so time_o reflects it 1 cycle later.
  - First increment occurs DIV cycles after state_o becomes RUN.
- Counter cascade:
  - cs 99 -> 0 carries to sec.
  - sec 59 -> 0 carries to min.
  - min 59 -> 0 carries to hours.
  - hours 99 -> 0 sets overflow_o, which stays set until CLEAR or reset.
  - Unused high bits of each byte are 0.
- LAP accepted in RUN or PAUSE:
  - lap_time_o <= time_o as presented in the accept cycle, i.e. the pre-increment value if a tick coincides.
  - lap_valid_o pulses 1 cycle, registered.
  - lap_time_o holds until the next LAP, CLEAR or reset.
- CLEAR also zeroes lap_time_o.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined: LAP capture as described above.
- Undefined: LAP op is accepted and ignored; lap_time_o and lap_valid_o are tied 0; no lap register is inferred.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum sw_state_e (IDLE/RUN/PAUSE/CLR).
  - op enum sw_op_e.
  - localparams CS_MAX=99, SEC_MAX=59, MIN_MAX=59, HR_MAX=99, field widths.
  - packed struct sw_time_t {hr, min, sec, cs} with 8-bit fields.
- Sub-module stopwatch_time_counter:
  - Inputs: ACLK, ARESETN, clr, tick.
  - Outputs: sw_time_t and an overflow strobe.
  - Contains only the carry cascade.
- Top holds the FSM, arbitration, prescaler and lap register.

Test Plan (CLK_FREQ_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset release, then START. Expected: state_o=1 next edge; time_o=0x00000001 exactly 10 cycles after RUN is visible; 0x00000100 after 1000 cycles.
- RUN 37 cycles, STOP, wait 50, START, run 3 cycles. Expected: time_o=0x00000003 then cs=4 at cycle 40 of accumulated RUN (prescaler retained).
- Preload by running to 99:59:59.99, then one tick. Expected: time_o=0x00000000 and overflow_o=1; CLEAR gives overflow_o=0 and cmd_ready=0 for one cycle.
- cmd_valid STOP and btn_start_stop in the same cycle while in RUN. Expected: state PAUSE (software wins, button dropped).
- LAP on a tick edge with time 0x00000009. Expected: lap_time_o=0x00000009, lap_valid_o high exactly 1 cycle. Without STOPWATCH_LAP_EN: lap_time_o=0 and lap_valid_o never high.
- ARESETN low for 3 cycles mid-RUN at 0x00010203. Expected: all outputs 0 asynchronously; state IDLE after release.
